// File: rtl/route_pkg.sv
// Shared types and header-field widths for the routing path.
// Header widths are shared with packet_buffer.
package route_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned LEN_WIDTH  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StDecide,
        StWaitCredit,
        StStream,
        StSettle
    } route_state_t;

endpackage

// File: rtl/credit_counter.sv
// Per-port flit credit register: saturating return/subtract and a sufficiency compare.
module credit_counter
    import route_pkg::*;
#(
    parameter int unsigned MaxCredits = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ret_i,
    input  logic                 take_i,
    input  logic [LEN_WIDTH-1:0] amount_i,
    output logic                 enough_o
);

    localparam int unsigned CW = $clog2(MaxCredits + 1);
    localparam int unsigned SW = ((CW > LEN_WIDTH) ? CW : LEN_WIDTH) + 2;

    logic [CW-1:0] credit_q, credit_d;
    logic [SW-1:0] inc, dec;

    always_comb begin
        // A return to an already full port is discarded before the subtraction.
        inc = SW'(credit_q) + SW'(ret_i && (credit_q != CW'(MaxCredits)));
        dec = take_i ? SW'(amount_i) : '0;
        if (dec > inc) begin
            credit_d = '0;
        end else if ((inc - dec) > SW'(MaxCredits)) begin
            credit_d = CW'(MaxCredits);
        end else begin
            credit_d = CW'(inc - dec);
        end
    end

    assign enough_o = SW'(credit_q) >= SW'(amount_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= CW'(MaxCredits);
        end else begin
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/route_control.sv
// Routing controller behind packet_buffer: header decode, credit-gated stream/drop, flit forwarding.
// Define ROUTE_TIMEOUT_EN to drop packets that wait TIMEOUT_CYCLES for credit.
module route_control
    import route_pkg::*;
#(
    parameter int unsigned FLIT_SIZE      = 64,
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned PORT_CREDITS   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  packet_ready_i,
    input  logic [ADDR_WIDTH-1:0] to_addr_i,
    input  logic [ADDR_WIDTH-1:0] from_addr_i,
    input  logic [LEN_WIDTH-1:0]  packet_length_i,
    input  logic [FLIT_SIZE-1:0]  in_flit_i,
    input  logic                  in_flit_valid_i,
    input  logic [N_PORTS-1:0]    credit_return_i,
    output logic                  stream_o,
    output logic                  drop_o,
    output logic                  control_valid_o,
    output logic [FLIT_SIZE-1:0]  out_flit_o,
    output logic                  out_flit_valid_o,
    output logic [N_PORTS-1:0]    out_port_o,
    output logic                  out_last_o,
    output logic [15:0]           n_routed_o,
    output logic [15:0]           n_dropped_o,
    output logic [7:0]            stray_flits_o
);

    localparam int unsigned PW = $clog2(N_PORTS);

    if (N_PORTS < 2 || (N_PORTS & (N_PORTS - 1)) != 0) begin : g_bad_ports
        $error("N_PORTS must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    route_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] to_q, to_d, from_q, from_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic                  stream_q, stream_d, drop_q, drop_d, cv_q, cv_d;
    logic [FLIT_SIZE-1:0]  flit_q, flit_d;
    logic                  fvalid_q, fvalid_d, last_q, last_d;
    logic [N_PORTS-1:0]    port_q, port_d, take, enough;
    logic [15:0]           routed_q, routed_d, dropped_q, dropped_d;
    logic [7:0]            stray_q, stray_d;
    logic [PW-1:0]         port;
    logic                  drop_cond;

    assign port      = to_q[PW-1:0];
    assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
    assign drop_cond = (len_q == '0) || (to_q == from_q) || (32'(len_q) > PORT_CREDITS);

    for (genvar p = 0; p < N_PORTS; p++) begin : g_credit
        credit_counter #(
            .MaxCredits(PORT_CREDITS)
        ) u_credit (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .ret_i   (credit_return_i[p]),
            .take_i  (take[p]),
            .amount_i(len_q),
            .enough_o(enough[p])
        );
    end

`ifdef ROUTE_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_q, wait_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        from_d    = from_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        stream_d  = 1'b0;
        drop_d    = 1'b0;
        flit_d    = flit_q;
        fvalid_d  = 1'b0;
        last_d    = 1'b0;
        port_d    = port_q;
        take      = '0;
        routed_d  = routed_q;
        dropped_d = dropped_q;
        stray_d   = stray_q;
`ifdef ROUTE_TIMEOUT_EN
        wait_d    = wait_q;
`endif

        if (in_flit_valid_i && state_q != StStream && stray_q != 8'hFF) begin
            stray_d = stray_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (packet_ready_i) begin
                    to_d    = to_addr_i;
                    from_d  = from_addr_i;
                    len_d   = packet_length_i;
                    state_d = StDecide;
                end
            end
            StDecide: begin
                if (drop_cond) begin
                    drop_d    = 1'b1;
                    dropped_d = dropped_q + 16'd1;
                    state_d   = StSettle;
                end else begin
                    state_d = StWaitCredit;
`ifdef ROUTE_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            StWaitCredit: begin
                // Credit availability wins over a timeout in the same cycle.
                if (enough[port]) begin
                    stream_d   = 1'b1;
                    take[port] = 1'b1;
                    cnt_d      = '0;
                    port_d     = N_PORTS'(1) << port;
                    state_d    = StStream;
                end
`ifdef ROUTE_TIMEOUT_EN
                else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    drop_d    = 1'b1;
                    dropped_d = dropped_q + 16'd1;
                    state_d   = StSettle;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
`endif
            end
            StStream: begin
                if (in_flit_valid_i) begin
                    fvalid_d = 1'b1;
                    flit_d   = in_flit_i;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) begin
                        last_d   = 1'b1;
                        routed_d = routed_q + 16'd1;
                        state_d  = StSettle;
                    end
                end
            end
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        cv_d = stream_d | drop_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            to_q      <= '0;
            from_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            stream_q  <= 1'b0;
            drop_q    <= 1'b0;
            cv_q      <= 1'b0;
            flit_q    <= '0;
            fvalid_q  <= 1'b0;
            last_q    <= 1'b0;
            port_q    <= '0;
            routed_q  <= '0;
            dropped_q <= '0;
            stray_q   <= '0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            from_q    <= from_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            stream_q  <= stream_d;
            drop_q    <= drop_d;
            cv_q      <= cv_d;
            flit_q    <= flit_d;
            fvalid_q  <= fvalid_d;
            last_q    <= last_d;
            port_q    <= port_d;
            routed_q  <= routed_d;
            dropped_q <= dropped_d;
            stray_q   <= stray_d;
        end
    end

    assign stream_o         = stream_q;
    assign drop_o           = drop_q;
    assign control_valid_o  = cv_q;
    assign out_flit_o       = flit_q;
    assign out_flit_valid_o = fvalid_q;
    assign out_port_o       = port_q;
    assign out_last_o       = last_q;
    assign n_routed_o       = routed_q;
    assign n_dropped_o      = dropped_q;
    assign stray_flits_o    = stray_q;

endmodule

// File: tb/tb_route_control.sv
// Self-checking bench for route_control against a packet-level reference model.
// Build with ROUTE_TIMEOUT_EN to also exercise the credit-wait timeout.
module tb_route_control;
    import route_pkg::*;

    localparam int FS = 64;
    localparam int NP = 4;
    localparam int PC = 32;
`ifdef ROUTE_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  packet_ready;
    logic [ADDR_WIDTH-1:0] to_addr, from_addr;
    logic [LEN_WIDTH-1:0]  packet_length;
    logic [FS-1:0]         in_flit;
    logic                  in_flit_valid;
    logic [NP-1:0]         credit_return;
    logic                  stream, drop, control_valid;
    logic [FS-1:0]         out_flit;
    logic                  out_flit_valid;
    logic [NP-1:0]         out_port;
    logic                  out_last;
    logic [15:0]           n_routed, n_dropped;
    logic [7:0]            stray_flits;

    route_control #(
        .FLIT_SIZE(FS),
        .N_PORTS(NP),
        .PORT_CREDITS(PC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .packet_ready_i  (packet_ready),
        .to_addr_i       (to_addr),
        .from_addr_i     (from_addr),
        .packet_length_i (packet_length),
        .in_flit_i       (in_flit),
        .in_flit_valid_i (in_flit_valid),
        .credit_return_i (credit_return),
        .stream_o        (stream),
        .drop_o          (drop),
        .control_valid_o (control_valid),
        .out_flit_o      (out_flit),
        .out_flit_valid_o(out_flit_valid),
        .out_port_o      (out_port),
        .out_last_o      (out_last),
        .n_routed_o      (n_routed),
        .n_dropped_o     (n_dropped),
        .stray_flits_o   (stray_flits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int credit_m[NP];
    int routed_m, dropped_m, stray_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) credit_m[p] = PC;
        routed_m  = 0;
        dropped_m = 0;
        stray_m   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stream"}, 64'(stream), 64'd0);
        chk({tag, "_drop"}, 64'(drop), 64'd0);
        chk({tag, "_cv"}, 64'(control_valid), 64'd0);
        chk({tag, "_ovalid"}, 64'(out_flit_valid), 64'd0);
        chk({tag, "_olast"}, 64'(out_last), 64'd0);
        chk({tag, "_oflit"}, out_flit, 64'd0);
        chk({tag, "_oport"}, 64'(out_port), 64'd0);
        chk({tag, "_routed"}, 64'(n_routed), 64'd0);
        chk({tag, "_dropped"}, 64'(n_dropped), 64'd0);
        chk({tag, "_stray"}, 64'(stray_flits), 64'd0);
    endtask

    // Random credit returns while idle; the model saturates at PC.
    task automatic idle_returns();
        int n;
        logic [NP-1:0] r;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            r = NP'($urandom_range(0, (1 << NP) - 1));
            credit_return = r;
            for (int p = 0; p < NP; p++)
                if (r[p] && credit_m[p] < PC) credit_m[p]++;
            step();
        end
        credit_return = '0;
    endtask

    task automatic run_packet(input int to, input int from, input int len, input bit allow_ret);
        int port, need;
        bit exp_drop;
        logic [NP-1:0] onehot;
        logic [FS-1:0] data;
        port     = to % NP;
        onehot   = NP'(1) << port;
        exp_drop = (len == 0) || (to == from) || (len > PC);

        packet_ready  = 1'b1;
        to_addr       = ADDR_WIDTH'(to);
        from_addr     = ADDR_WIDTH'(from);
        packet_length = LEN_WIDTH'(len);
        step();
        packet_ready = 1'b0;
        chk("cv_cycle1", 64'(control_valid), 64'd0);
        step();
        if (exp_drop) begin
            chk("drop_pulse", 64'(drop), 64'd1);
            chk("drop_no_stream", 64'(stream), 64'd0);
            chk("drop_cv", 64'(control_valid), 64'd1);
            dropped_m++;
            chk("n_dropped", 64'(n_dropped), 64'(dropped_m));
            step();
            chk("drop_one_cycle", 64'(control_valid), 64'd0);
            chk("drop_no_flit", 64'(out_flit_valid), 64'd0);
            return;
        end
        chk("cv_cycle2", 64'(control_valid), 64'd0);
        need = len - credit_m[port];
        if (need <= 0) begin
            step();
        end else if (TO_EN && (!allow_ret || need > TO - 2)) begin
            for (int c = 3; c < 2 + TO; c++) begin
                step();
                chk("timeout_wait_cv", 64'(control_valid), 64'd0);
            end
            step();
            chk("timeout_drop", 64'(drop), 64'd1);
            chk("timeout_cv", 64'(control_valid), 64'd1);
            dropped_m++;
            chk("timeout_n_dropped", 64'(n_dropped), 64'(dropped_m));
            step();
            return;
        end else begin
            step();
            for (int i = 0; i < need; i++) begin
                credit_return = onehot;
                chk("wait_hold_cv", 64'(control_valid), 64'd0);
                step();
            end
            credit_return = '0;
            chk("wait_hold_last", 64'(control_valid), 64'd0);
            credit_m[port] = len;
            step();
        end
        chk("stream_pulse", 64'(stream), 64'd1);
        chk("stream_no_drop", 64'(drop), 64'd0);
        chk("stream_cv", 64'(control_valid), 64'd1);
        credit_m[port] -= len;

        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_flit_valid = 1'b0;
                step();
                chk("gap_no_flit", 64'(out_flit_valid), 64'd0);
            end
            data          = {$urandom, $urandom};
            in_flit       = data;
            in_flit_valid = 1'b1;
            step();
            if (i == 0) chk("stream_one_cycle", 64'(control_valid), 64'd0);
            chk("flit_valid", 64'(out_flit_valid), 64'd1);
            chk("flit_data", out_flit, data);
            chk("flit_port", 64'(out_port), 64'(onehot));
            chk("flit_last", 64'(out_last), 64'(i == len - 1));
        end
        in_flit_valid = 1'b0;
        routed_m++;
        chk("n_routed", 64'(n_routed), 64'(routed_m));
        chk("no_stray_in_stream", 64'(stray_flits), 64'(stray_m));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        packet_ready  = 1'b0;
        to_addr       = '0;
        from_addr     = '0;
        packet_length = '0;
        in_flit       = '0;
        in_flit_valid = 1'b0;
        credit_return = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Basic stream to port 1 (credit 32 -> 29), then the three drop rules.
        run_packet(8'h05, 8'h01, 3, 1'b1);
        run_packet(8'h07, 8'h07, 3, 1'b1);
        run_packet(8'h09, 8'h01, 40, 1'b1);
        run_packet(8'h09, 8'h01, 0, 1'b1);

        // Port 2: second 20-flit packet needs 8 returns.
        run_packet(8'h02, 8'h00, 20, 1'b1);
        run_packet(8'h02, 8'h00, 20, 1'b1);
`ifdef ROUTE_TIMEOUT_EN
        run_packet(8'h02, 8'h00, 5, 1'b0);
`endif
        // Port 1 holds exactly 29 credits: 29 streams at once, 1 more must wait.
        run_packet(8'h01, 8'h00, 29, 1'b1);
        run_packet(8'h01, 8'h00, 1, 1'b1);

        // Stray flits while idle.
        for (int i = 0; i < 3; i++) begin
            in_flit       = {$urandom, $urandom};
            in_flit_valid = 1'b1;
            step();
            stray_m++;
            chk("stray_not_forwarded", 64'(out_flit_valid), 64'd0);
        end
        in_flit_valid = 1'b0;
        chk("stray_count", 64'(stray_flits), 64'(stray_m));

        for (int k = 0; k < 30; k++) begin
            int to, from, len, r;
            idle_returns();
            to   = $urandom_range(0, 255);
            from = ($urandom_range(0, 7) == 0) ? to : $urandom_range(0, 255);
            r    = $urandom_range(0, 19);
            len  = (r == 0) ? 0 : (r == 1) ? $urandom_range(33, 255) : $urandom_range(1, PC);
            run_packet(to, from, len, 1'b1);
        end

        // Reset in the middle of a stream to port 3.
        credit_return = '1;
        for (int i = 0; i < PC; i++) step();
        credit_return = '0;
        for (int p = 0; p < NP; p++) credit_m[p] = PC;
        packet_ready  = 1'b1;
        to_addr       = 8'h03;
        from_addr     = 8'h00;
        packet_length = 8'd4;
        step();
        packet_ready = 1'b0;
        step();
        step();
        chk("mid_stream_pulse", 64'(stream), 64'd1);
        in_flit       = 64'hDEAD_BEEF_0123_4567;
        in_flit_valid = 1'b1;
        step();
        chk("mid_flit_valid", 64'(out_flit_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        in_flit_valid = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            in_flit       = {$urandom, $urandom};
            in_flit_valid = 1'b1;
            step();
            stray_m++;
            chk("post_reset_no_flit", 64'(out_flit_valid), 64'd0);
        end
        in_flit_valid = 1'b0;
        chk("post_reset_stray", 64'(stray_flits), 64'(stray_m));
        run_packet(8'h03, 8'h00, PC, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
